// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags.
// Combinational value-or-tag reads, commit writeback, rename claim, flush.
module reg_file_rename #(
  parameter int REG_NUM  = 32,
  parameter int DATA_W   = 32,
  parameter int ROB_ID_W = 4,
  localparam int IDX_W   = $clog2(REG_NUM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic [IDX_W-1:0]    rs1,
  input  logic [IDX_W-1:0]    rs2,
  output logic [DATA_W-1:0]   rs1_val,
  output logic                rs1_busy,
  output logic [ROB_ID_W-1:0] rs1_tag,
  output logic [DATA_W-1:0]   rs2_val,
  output logic                rs2_busy,
  output logic [ROB_ID_W-1:0] rs2_tag,
  input  logic                rename_en,
  input  logic [IDX_W-1:0]    rename_rd,
  input  logic [ROB_ID_W-1:0] rename_rob_id,
  input  logic                commit_en,
  input  logic [IDX_W-1:0]    commit_rd,
  input  logic [ROB_ID_W-1:0] commit_rob_id,
  input  logic [DATA_W-1:0]   commit_value
);

  logic [DATA_W-1:0]   val_q  [REG_NUM];
  logic [ROB_ID_W-1:0] tag_q  [REG_NUM];
  logic [REG_NUM-1:0]  busy_q;

  logic commit_wr;
  logic rename_wr;
  logic commit_match;

  assign commit_wr = rdy && commit_en
                  && (commit_rd != '0);
  assign rename_wr = rdy && !flush && rename_en
                  && (rename_rd != '0);

  // tag clear only when the committing entry is still the newest writer
  assign commit_match = busy_q[commit_rd]
                     && (tag_q[commit_rd] == commit_rob_id);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i]  <= '0;
        tag_q[i]  <= '0;
        busy_q[i] <= 1'b0;
      end
    end else if (rdy) begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (commit_wr && commit_rd == IDX_W'(i))
          val_q[i] <= commit_value;
        if (flush) begin
          busy_q[i] <= 1'b0;
          tag_q[i]  <= '0;
        end else if (rename_wr
                     && rename_rd == IDX_W'(i)) begin
          busy_q[i] <= 1'b1;
          tag_q[i]  <= rename_rob_id;
        end else if (commit_wr && commit_match
                     && commit_rd == IDX_W'(i)) begin
          busy_q[i] <= 1'b0;
          tag_q[i]  <= '0;
        end
      end
    end
  end

  logic rs1_byp;
  logic rs2_byp;

  assign rs1_byp = commit_en && (commit_rd == rs1)
                && busy_q[rs1]
                && (tag_q[rs1] == commit_rob_id);
  assign rs2_byp = commit_en && (commit_rd == rs2)
                && busy_q[rs2]
                && (tag_q[rs2] == commit_rob_id);

  always_comb begin
    rs1_val  = val_q[rs1];
    rs1_busy = busy_q[rs1];
    rs1_tag  = busy_q[rs1] ? tag_q[rs1] : '0;
    if (rs1 == '0) begin
      rs1_val  = '0;
      rs1_busy = 1'b0;
      rs1_tag  = '0;
    end else if (rs1_byp) begin
      rs1_val  = commit_value;
      rs1_busy = 1'b0;
      rs1_tag  = '0;
    end
  end

  always_comb begin
    rs2_val  = val_q[rs2];
    rs2_busy = busy_q[rs2];
    rs2_tag  = busy_q[rs2] ? tag_q[rs2] : '0;
    if (rs2 == '0) begin
      rs2_val  = '0;
      rs2_busy = 1'b0;
      rs2_tag  = '0;
    end else if (rs2_byp) begin
      rs2_val  = commit_value;
      rs2_busy = 1'b0;
      rs2_tag  = '0;
    end
  end

endmodule

// File: tb/tb_reg_file_rename.sv
// Bench for reg_file_rename: directed scenarios plus a
// randomized phase, expectations queued and compared at negedge.
module tb_reg_file_rename;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] rs1_val, rs2_val;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_tag, rs2_tag;
  logic        rename_en = 1'b0;
  logic [4:0]  rename_rd = '0;
  logic [3:0]  rename_rob_id = '0;
  logic        commit_en = 1'b0;
  logic [4:0]  commit_rd = '0;
  logic [3:0]  commit_rob_id = '0;
  logic [31:0] commit_value = '0;

  reg_file_rename dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .rs1(rs1), .rs2(rs2),
    .rs1_val(rs1_val), .rs1_busy(rs1_busy),
    .rs1_tag(rs1_tag),
    .rs2_val(rs2_val), .rs2_busy(rs2_busy),
    .rs2_tag(rs2_tag),
    .rename_en(rename_en), .rename_rd(rename_rd),
    .rename_rob_id(rename_rob_id),
    .commit_en(commit_en), .commit_rd(commit_rd),
    .commit_rob_id(commit_rob_id),
    .commit_value(commit_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        port;
    logic [31:0] val;
    logic        busy;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic expect_rd(input string name,
                           input logic port,
                           input logic [31:0] v,
                           input logic b,
                           input logic [3:0] t);
    exp_t e;
    e.name = name;
    e.port = port;
    e.val  = v;
    e.busy = b;
    e.tag  = t;
    sb.push_back(e);
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t e;
      logic [63:0] obs;
      e = sb.pop_front();
      obs = e.port ? {27'b0, rs2_val, rs2_busy, rs2_tag}
                   : {27'b0, rs1_val, rs1_busy, rs1_tag};
      check(e.name, obs, {27'b0, e.val, e.busy, e.tag});
    end
  endtask

  task automatic sample();
    @(negedge clk);
    drain();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy       = 1'b1;
    flush     = 1'b0;
    rename_en = 1'b0;
    commit_en = 1'b0;
  endtask

  task automatic rename(input logic [4:0] rd,
                        input logic [3:0] id);
    rename_en     = 1'b1;
    rename_rd     = rd;
    rename_rob_id = id;
  endtask

  task automatic commit(input logic [4:0] rd,
                        input logic [3:0] id,
                        input logic [31:0] v);
    commit_en     = 1'b1;
    commit_rd     = rd;
    commit_rob_id = id;
    commit_value  = v;
  endtask

  task automatic read2(input string name,
                       input logic [4:0] a,
                       input logic [4:0] b,
                       input logic [31:0] v1,
                       input logic b1,
                       input logic [3:0] t1,
                       input logic [31:0] v2,
                       input logic b2,
                       input logic [3:0] t2);
    rs1 = a;
    rs2 = b;
    expect_rd({name, "_p1"}, 1'b0, v1, b1, t1);
    expect_rd({name, "_p2"}, 1'b1, v2, b2, t2);
    sample();
  endtask

  function automatic logic [36:0] model_rd(
      input logic [4:0] r);
    if (r == 0)
      return '0;
    if (commit_en && commit_rd == r && m_busy[r]
        && m_tag[r] == commit_rob_id)
      return {commit_value, 1'b0, 4'h0};
    return {m_val[r], m_busy[r],
            m_busy[r] ? m_tag[r] : 4'h0};
  endfunction

  task automatic model_step();
    if (!rdy)
      return;
    if (commit_en && commit_rd != 0) begin
      m_val[commit_rd] = commit_value;
      if (m_busy[commit_rd]
          && m_tag[commit_rd] == commit_rob_id) begin
        m_busy[commit_rd] = 1'b0;
        m_tag[commit_rd]  = 4'h0;
      end
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) begin
        m_busy[i] = 1'b0;
        m_tag[i]  = 4'h0;
      end
    end else if (rename_en && rename_rd != 0) begin
      m_busy[rename_rd] = 1'b1;
      m_tag[rename_rd]  = rename_rob_id;
    end
  endtask

  initial begin
    logic [36:0] p;

    // reset state
    rs1 = 5'd5;
    rs2 = 5'd0;
    expect_rd("rst_p1", 1'b0, 32'h0, 1'b0, 4'h0);
    expect_rd("rst_p2", 1'b1, 32'h0, 1'b0, 4'h0);
    #3;
    drain();
    tick();
    rst = 1'b0;
    tick();

    // rename, bypass on commit, stored value
    rename(5, 3);
    tick(); idle();
    read2("ren5", 5, 0, 0, 1, 3, 0, 0, 0);
    tick();
    commit(5, 3, 32'hDEAD_BEEF);
    read2("byp5", 5, 5, 32'hDEAD_BEEF, 0, 0,
          32'hDEAD_BEEF, 0, 0);
    tick(); idle();
    read2("st5", 5, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    tick();

    // older commit leaves younger tag pending
    rename(7, 2);
    tick();
    rename(7, 9);
    tick(); idle();
    commit(7, 2, 32'h11);
    read2("old7", 7, 7, 0, 1, 9, 0, 1, 9);
    tick(); idle();
    read2("c7a", 7, 0, 32'h11, 1, 9, 0, 0, 0);
    tick();
    commit(7, 9, 32'h22);
    read2("byp7", 7, 0, 32'h22, 0, 0, 0, 0, 0);
    tick(); idle();
    read2("c7b", 7, 0, 32'h22, 0, 0, 0, 0, 0);
    tick();

    // same-cycle commit and rename on one rd
    commit(4, 1, 32'h55);
    rename(4, 6);
    tick(); idle();
    read2("cr4", 4, 0, 32'h55, 1, 6, 0, 0, 0);
    tick();

    // flush with simultaneous commit and rename
    rename(1, 10);
    tick();
    rename(2, 11);
    tick();
    rename(3, 12);
    tick(); idle();
    read2("ren13", 1, 3, 0, 1, 10, 0, 1, 12);
    tick();
    flush = 1'b1;
    commit(2, 11, 32'h99);
    rename(8, 13);
    read2("flbyp", 2, 8, 32'h99, 0, 0, 0, 0, 0);
    tick(); idle();
    read2("fl28", 2, 8, 32'h99, 0, 0, 0, 0, 0);
    tick();
    read2("fl13", 1, 3, 0, 0, 0, 0, 0, 0);
    tick();
    read2("fl45", 4, 5, 32'h55, 0, 0,
          32'hDEAD_BEEF, 0, 0);
    tick();

    // x0 writes ignored
    rename(0, 4);
    commit(0, 0, 32'hFF);
    read2("x0a", 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); idle();
    read2("x0b", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // rdy low freezes state
    rdy = 1'b0;
    rename(6, 5);
    commit(4, 0, 32'h77);
    read2("frz", 6, 4, 0, 0, 0, 32'h55, 0, 0);
    tick(); idle();
    read2("frz2", 6, 4, 0, 0, 0, 32'h55, 0, 0);
    tick();
    rename(9, 1);
    tick(); idle();
    rdy   = 1'b0;
    flush = 1'b1;
    read2("frzfl", 9, 0, 0, 1, 1, 0, 0, 0);
    tick(); idle();
    read2("frzfl2", 9, 0, 0, 1, 1, 0, 0, 0);
    tick();

    // asynchronous reset mid-cycle
    read2("pre_rst", 5, 2, 32'hDEAD_BEEF, 0, 0,
          32'h99, 0, 0);
    #1 rst = 1'b1;
    #1;
    expect_rd("arst_p1", 1'b0, 32'h0, 1'b0, 4'h0);
    expect_rd("arst_p2", 1'b1, 32'h0, 1'b0, 4'h0);
    drain();
    #1 rst = 1'b0;
    tick();
    read2("post_rst", 9, 4, 0, 0, 0, 0, 0, 0);
    tick();

    // randomized traffic against a reference model
    for (int i = 0; i < 32; i++) begin
      m_val[i]  = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
    for (int n = 0; n < 400; n++) begin
      rdy           = ($urandom_range(0, 9) != 0);
      flush         = ($urandom_range(0, 19) == 0);
      rename_en     = $urandom_range(0, 1) == 1;
      rename_rd     = 5'($urandom_range(0, 7));
      rename_rob_id = 4'($urandom);
      commit_en     = $urandom_range(0, 1) == 1;
      commit_rd     = 5'($urandom_range(0, 7));
      commit_rob_id = ($urandom_range(0, 3) != 0)
                    ? m_tag[commit_rd] : 4'($urandom);
      commit_value  = $urandom;
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      p = model_rd(rs1);
      expect_rd("rnd_p1", 1'b0, p[36:5], p[4], p[3:0]);
      p = model_rd(rs2);
      expect_rd("rnd_p2", 1'b1, p[36:5], p[4], p[3:0]);
      sample();
      tick();
      model_step();
    end
    idle();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file with per-register rename tags.
- Sits directly downstream of the reorder buffer commit port and beside the dispatcher.
- Dispatcher reads rs1/rs2 value-or-tag and claims rd for a new ROB entry.
- On commit, the ROB writes the result into rd and clears the tag if the tag still matches.

Parameters:
REG_NUM, 32, number of architectural registers (index width log2 = 5)
DATA_W, 32, register data width
ROB_ID_W, 4, ROB entry id width (16-entry ROB)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
rdy  input  1  global ready; low freezes all state
flush  input  1  mispredict flush; clears every rename tag
rs1  input  5  dispatcher read index 1
rs2  input  5  dispatcher read index 2
rs1_val  output  DATA_W  value of rs1 (valid when rs1_busy=0)
rs1_busy  output  1  rs1 awaits an in-flight ROB entry
rs1_tag  output  ROB_ID_W  ROB id producing rs1 (0 when not busy)
rs2_val  output  DATA_W  as rs1_val for rs2
rs2_busy  output  1  as rs1_busy for rs2
rs2_tag  output  ROB_ID_W  as rs1_tag for rs2
rename_en  input  1  dispatcher claims rename_rd this cycle
rename_rd  input  5  destination register being renamed
rename_rob_id  input  ROB_ID_W  ROB entry allocated to rename_rd
commit_en  input  1  ROB commits one entry this cycle
commit_rd  input  5  destination register of committing entry
commit_rob_id  input  ROB_ID_W  ROB id of committing entry
commit_value  input  DATA_W  result to write

Behaviour:
- State: val[REG_NUM], busy[REG_NUM], tag[REG_NUM].
- Reset (async, rst=1): all val=0, busy=0, tag=0, effective immediately, not at the clock edge. Read outputs therefore show 0/0/0.
- Reads are combinational, zero latency.
  - rsX=0: always val=0, busy=0, tag=0.
  - Bypass: commit_en && commit_rd==rsX && rsX!=0 && busy[rsX] && tag[rsX]==commit_rob_id gives val=commit_value, busy=0, tag=0.
  - Otherwise outputs are val[rsX], busy[rsX], tag[rsX]; tag is forced to 0 when not busy.
  - Reads never observe a rename issued in the same cycle; the dispatcher reads operands before claiming its rd.
- Commit (posedge, rdy=1, commit_en=1, commit_rd!=0):
  - val[commit_rd] <= commit_value unconditionally.
  - If busy && tag==commit_rob_id, then busy <= 0 and tag <= 0.
  - If the tag differs (a younger writer is pending), busy and tag are untouched.
- Rename (posedge, rdy=1, flush=0, rename_en=1, rename_rd!=0): busy[rename_rd] <= 1, tag[rename_rd] <= rename_rob_id.
- Commit and rename on the same rd in the same cycle: val takes commit_value, busy=1, tag=rename_rob_id. Rename has priority over tag clear.
- Flush (posedge, rdy=1):
  - All busy <= 0, all tag <= 0.
  - A simultaneous commit still writes val; a simultaneous rename is dropped.
  - Flush is level-sampled; holding it for multiple cycles repeats the clear.
- rdy=0: no state change; combinational reads stay live.
- Writes to x0 (commit or rename) are ignored; x0 stays 0/not busy.
- ROB id wrap-around needs no special handling. Tags are compared for equality only, and the ROB never has two live entries with the same id.

Test Plan:
- Reset then read rs1=5, rs2=0: both give val=0, busy=0, tag=0. Assert rst mid-run after writes: outputs return to 0 before the next clk edge.
- Rename x5->rob 3; next cycle read x5 gives busy=1, tag=3. Commit rd=5, id=3, value 0xDEADBEEF: same-cycle read gives 0xDEADBEEF, busy=0 (bypass). Next cycle it is stored.
- Rename x7->rob 2, then x7->rob 9. Commit rd=7, id=2, value 0x11: val=0x11, busy=1, tag=9. Commit id=9, value 0x22: busy=0, val=0x22.
- Same-cycle commit rd=4, id=1, value 0x55 and rename rd=4->rob 6: next cycle val=0x55, busy=1, tag=6.
- Rename x1..x3 to rob 10..12, then flush with simultaneous commit rd=2, value 0x99 and rename x8->rob 13: all busy=0, x2=0x99, x8 not busy.
- Rename rd=0->rob 4 and commit rd=0, value 0xFF: x0 reads 0, busy=0. With rdy=0, rename x6->rob 5 has no effect.
